// File: rtl/tmr_mon_pkg.sv
// Shared types, encodings and helpers for the TMR fault monitor.
package tmr_mon_pkg;

    typedef enum logic [1:0] {
        NORMAL   = 2'b00,
        DEGRADED = 2'b01,
        FAILED   = 2'b10
    } mon_state_t;

    localparam logic [1:0] MAJ_ALL  = 2'b00;
    localparam logic [1:0] MAJ_ONE  = 2'b01;
    localparam logic [1:0] MAJ_NONE = 2'b10;

    localparam logic [1:0] ID_UNCORR = 2'd0;
    localparam logic [1:0] ID_ALU1   = 2'd1;
    localparam logic [1:0] ID_ALU2   = 2'd2;
    localparam logic [1:0] ID_ALU3   = 2'd3;

    typedef struct packed {
        logic       ev_single;
        logic       ev_uncorr;
        logic [1:0] id;
    } vote_class_t;

    // Decode the pairwise match flags and cross-check them against the voter status.
    function automatic vote_class_t classify_vote(input logic m12, input logic m13,
                                                  input logic m23, input logic [1:0] status);
        vote_class_t c;
        c.ev_single = 1'b0;
        c.ev_uncorr = 1'b0;
        c.id        = ID_UNCORR;
        case ({m12, m13, m23})
            3'b111: c.ev_uncorr = (status != MAJ_ALL);
            3'b100: begin
                if (status == MAJ_ONE) begin c.ev_single = 1'b1; c.id = ID_ALU3; end
                else c.ev_uncorr = 1'b1;
            end
            3'b010: begin
                if (status == MAJ_ONE) begin c.ev_single = 1'b1; c.id = ID_ALU2; end
                else c.ev_uncorr = 1'b1;
            end
            3'b001: begin
                if (status == MAJ_ONE) begin c.ev_single = 1'b1; c.id = ID_ALU1; end
                else c.ev_uncorr = 1'b1;
            end
            default: c.ev_uncorr = 1'b1;
        endcase
        return c;
    endfunction

    // Number of set bits in a 3-bit vector.
    function automatic logic [1:0] count_ones3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

endpackage

// File: rtl/fault_log_fifo.sv
// Fault event log: registered FIFO, valid/ready pop, drop-on-full push with sticky overflow.
module fault_log_fifo #(
    parameter int unsigned W     = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clear,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_ok;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_pop     = !w_empty && i_ready;
    assign w_push_ok = i_push && (!w_full || w_pop);

    // Pointer, occupancy and overflow bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push_ok && !w_pop)      r_count <= r_count + (AW+1)'(1);
            else if (!w_push_ok && w_pop) r_count <= r_count - (AW+1)'(1);
            if (i_push && !w_push_ok) r_overflow <= 1'b1;
        end
    end

    // Entry storage; contents are masked while empty so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_clear) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_valid    = !w_empty;
    assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_overflow = r_overflow;

endmodule

// File: rtl/tmr_fault_monitor.sv
// TMR voter fault monitor: classifies voted ops, counts per-ALU errors, flags persistent
// single-ALU faults, logs events and raises a level interrupt.
// Optional macro TMR_MON_PC_LOG_EN: when defined, log entries carry the op PC.
module tmr_fault_monitor
    import tmr_mon_pkg::*;
#(
    parameter int unsigned N          = 64,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PERSIST_TH = 4,
    parameter int unsigned LOG_DEPTH  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_E,
    input  logic [N-1:0]     PC_E,
    input  logic             alu1_alu2_match,
    input  logic             alu1_alu3_match,
    input  logic             alu2_alu3_match,
    input  logic [1:0]       majority_status,
    input  logic             clear,
    output logic [CNT_W-1:0] err_cnt1,
    output logic [CNT_W-1:0] err_cnt2,
    output logic [CNT_W-1:0] err_cnt3,
    output logic [2:0]       alu_degraded,
    output logic [1:0]       mon_state,
    output logic             log_valid,
    input  logic             log_ready,
    output logic [N-1:0]     log_pc,
    output logic [1:0]       log_id,
    output logic             log_overflow,
    output logic             fault_irq
);

    localparam int unsigned CONS_W = 4;
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CONS_W-1:0] CONS_MAX = {CONS_W{1'b1}};
`ifdef TMR_MON_PC_LOG_EN
    localparam int unsigned LOG_W = N + 2;
`else
    localparam int unsigned LOG_W = 2;
`endif

    logic [CNT_W-1:0]  r_err_cnt [3];
    logic [CONS_W-1:0] r_consec  [3];
    logic [2:0]        r_deg;
    mon_state_t        r_state;

    vote_class_t       w_cls;
    logic              w_single;
    logic              w_uncorr;
    logic              w_no_evt;
    logic [CNT_W-1:0]  w_err_nxt    [3];
    logic [CONS_W-1:0] w_consec_nxt [3];
    logic [2:0]        w_deg_nxt;
    logic [1:0]        w_deg_cnt;
    logic              w_push;
    logic [LOG_W-1:0]  w_push_data;
    logic [LOG_W-1:0]  w_head;

    assign w_cls     = classify_vote(alu1_alu2_match, alu1_alu3_match, alu2_alu3_match,
                                     majority_status);
    assign w_single  = valid_E && w_cls.ev_single;
    assign w_uncorr  = valid_E && w_cls.ev_uncorr;
    assign w_no_evt  = valid_E && !w_cls.ev_single && !w_cls.ev_uncorr;
    assign w_deg_cnt = count_ones3(w_deg_nxt);

    // Next-state error counts, consecutive-fault runs and degraded flags.
    always_comb begin
        w_err_nxt    = r_err_cnt;
        w_consec_nxt = r_consec;
        w_deg_nxt    = r_deg;
        for (int i = 0; i < 3; i++) begin
            if (w_single) begin
                if (w_cls.id == 2'(i + 1)) begin
                    if (r_err_cnt[i] != CNT_MAX) w_err_nxt[i] = r_err_cnt[i] + CNT_W'(1);
                    if (r_consec[i] != CONS_MAX) w_consec_nxt[i] = r_consec[i] + CONS_W'(1);
                end else begin
                    w_consec_nxt[i] = '0;
                end
            end else if (w_no_evt) begin
                w_consec_nxt[i] = '0;
            end
            if (w_consec_nxt[i] == CONS_W'(PERSIST_TH)) w_deg_nxt[i] = 1'b1;
        end
    end

    // Statistics registers; clear wins over a same-cycle event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_err_cnt[i] <= '0;
                r_consec[i]  <= '0;
            end
            r_deg <= '0;
        end else if (clear) begin
            for (int i = 0; i < 3; i++) begin
                r_err_cnt[i] <= '0;
                r_consec[i]  <= '0;
            end
            r_deg <= '0;
        end else begin
            r_err_cnt <= w_err_nxt;
            r_consec  <= w_consec_nxt;
            r_deg     <= w_deg_nxt;
        end
    end

    // Health FSM, driven by the next-state degraded flags and this cycle's event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= NORMAL;
        end else if (clear) begin
            r_state <= NORMAL;
        end else begin
            case (r_state)
                NORMAL: begin
                    if (w_uncorr || (w_deg_cnt >= 2'd2)) r_state <= FAILED;
                    else if (w_deg_cnt == 2'd1)          r_state <= DEGRADED;
                end
                DEGRADED: begin
                    if (w_uncorr || (w_deg_cnt >= 2'd2)) r_state <= FAILED;
                end
                FAILED:  r_state <= FAILED;
                default: r_state <= NORMAL;
            endcase
        end
    end

    assign w_push = (w_single || w_uncorr) && !clear;

`ifdef TMR_MON_PC_LOG_EN
    assign w_push_data = {PC_E, w_cls.id};
    assign log_pc      = w_head[LOG_W-1:2];
`else
    logic w_unused_pc;
    assign w_unused_pc = ^PC_E;
    assign w_push_data = w_cls.id;
    assign log_pc      = '0;
`endif
    assign log_id = w_head[1:0];

    fault_log_fifo #(
        .W     (LOG_W),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (clear),
        .i_push     (w_push),
        .i_data     (w_push_data),
        .o_valid    (log_valid),
        .i_ready    (log_ready),
        .o_data     (w_head),
        .o_overflow (log_overflow)
    );

    assign err_cnt1     = r_err_cnt[0];
    assign err_cnt2     = r_err_cnt[1];
    assign err_cnt3     = r_err_cnt[2];
    assign alu_degraded = r_deg;
    assign mon_state    = r_state;
    assign fault_irq    = log_valid || (r_state == FAILED) || log_overflow;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Directed self-checking bench for tmr_fault_monitor.
module tb_tmr_fault_monitor;

    logic        clk;
    logic        rst_n;
    logic        valid_E;
    logic [63:0] PC_E;
    logic        alu1_alu2_match;
    logic        alu1_alu3_match;
    logic        alu2_alu3_match;
    logic [1:0]  majority_status;
    logic        clear;
    logic [15:0] err_cnt1;
    logic [15:0] err_cnt2;
    logic [15:0] err_cnt3;
    logic [2:0]  alu_degraded;
    logic [1:0]  mon_state;
    logic        log_valid;
    logic        log_ready;
    logic [63:0] log_pc;
    logic [1:0]  log_id;
    logic        log_overflow;
    logic        fault_irq;

    int checks;
    int failures;

`ifdef TMR_MON_PC_LOG_EN
    localparam bit PC_EN = 1'b1;
`else
    localparam bit PC_EN = 1'b0;
`endif

    tmr_fault_monitor dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_E         (valid_E),
        .PC_E            (PC_E),
        .alu1_alu2_match (alu1_alu2_match),
        .alu1_alu3_match (alu1_alu3_match),
        .alu2_alu3_match (alu2_alu3_match),
        .majority_status (majority_status),
        .clear           (clear),
        .err_cnt1        (err_cnt1),
        .err_cnt2        (err_cnt2),
        .err_cnt3        (err_cnt3),
        .alu_degraded    (alu_degraded),
        .mon_state       (mon_state),
        .log_valid       (log_valid),
        .log_ready       (log_ready),
        .log_pc          (log_pc),
        .log_id          (log_id),
        .log_overflow    (log_overflow),
        .fault_irq       (fault_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] exp_pc(input logic [63:0] pc);
        return PC_EN ? pc : 64'd0;
    endfunction

    // One voted op presented for one clock; returns at the following falling edge.
    task automatic do_op(input logic m12, input logic m13, input logic m23,
                         input logic [1:0] st, input logic [63:0] pc);
        valid_E = 1'b1;
        alu1_alu2_match = m12;
        alu1_alu3_match = m13;
        alu2_alu3_match = m23;
        majority_status = st;
        PC_E = pc;
        @(negedge clk);
        valid_E = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_E = 1'b0; PC_E = '0; clear = 1'b0; log_ready = 1'b0;
        alu1_alu2_match = 1'b0; alu1_alu3_match = 1'b0; alu2_alu3_match = 1'b0;
        majority_status = 2'b00;
        repeat (3) @(negedge clk);
        checks++; if ({err_cnt1, err_cnt2, err_cnt3} !== 48'd0) begin
            $display("FAIL reset_cnt got=%h exp=0", {err_cnt1, err_cnt2, err_cnt3}); failures++; end
        checks++; if ({alu_degraded, mon_state} !== 5'd0) begin
            $display("FAIL reset_state got=%b exp=00000", {alu_degraded, mon_state}); failures++; end
        checks++; if ({log_valid, log_overflow, fault_irq, log_id} !== 5'd0 || log_pc !== 64'd0) begin
            $display("FAIL reset_log got=%b pc=%h exp=0", {log_valid, log_overflow, fault_irq, log_id}, log_pc); failures++; end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_no_event();
        for (int i = 0; i < 10; i++) do_op(1'b1, 1'b1, 1'b1, 2'b00, 64'h100 + 64'(i));
        checks++; if ({err_cnt1, err_cnt2, err_cnt3} !== 48'd0) begin
            $display("FAIL noevt_cnt got=%h exp=0", {err_cnt1, err_cnt2, err_cnt3}); failures++; end
        checks++; if (mon_state !== 2'b00 || log_valid !== 1'b0 || fault_irq !== 1'b0) begin
            $display("FAIL noevt_flags got st=%b lv=%b irq=%b exp 00/0/0", mon_state, log_valid, fault_irq); failures++; end
    endtask

    task automatic test_single_alu3();
        do_op(1'b1, 1'b0, 1'b0, 2'b01, 64'h1000);
        checks++; if (err_cnt3 !== 16'd1 || err_cnt1 !== 16'd0 || err_cnt2 !== 16'd0) begin
            $display("FAIL alu3_cnt got=%0d/%0d/%0d exp=0/0/1", err_cnt1, err_cnt2, err_cnt3); failures++; end
        checks++; if (log_valid !== 1'b1 || log_id !== 2'd3 || fault_irq !== 1'b1) begin
            $display("FAIL alu3_log got lv=%b id=%0d irq=%b exp 1/3/1", log_valid, log_id, fault_irq); failures++; end
        checks++; if (log_pc !== exp_pc(64'h1000)) begin
            $display("FAIL alu3_pc got=%h exp=%h", log_pc, exp_pc(64'h1000)); failures++; end
        log_ready = 1'b1;
        @(negedge clk);
        log_ready = 1'b0;
        checks++; if (log_valid !== 1'b0 || fault_irq !== 1'b0 || log_pc !== 64'd0 || log_id !== 2'd0) begin
            $display("FAIL alu3_pop got lv=%b irq=%b id=%0d pc=%h exp 0/0/0/0", log_valid, fault_irq, log_id, log_pc); failures++; end
    endtask

    task automatic test_persist();
        for (int i = 0; i < 3; i++) do_op(1'b0, 1'b0, 1'b1, 2'b01, 64'h2000 + 64'(i));
        do_op(1'b1, 1'b1, 1'b1, 2'b00, 64'h2100);
        checks++; if (alu_degraded !== 3'b000 || mon_state !== 2'b00 || err_cnt1 !== 16'd3) begin
            $display("FAIL persist_broken got deg=%b st=%b c1=%0d exp 000/00/3", alu_degraded, mon_state, err_cnt1); failures++; end
        for (int i = 0; i < 3; i++) do_op(1'b0, 1'b0, 1'b1, 2'b01, 64'h2200 + 64'(i));
        checks++; if (alu_degraded !== 3'b000 || mon_state !== 2'b00) begin
            $display("FAIL persist_3 got deg=%b st=%b exp 000/00", alu_degraded, mon_state); failures++; end
        do_op(1'b0, 1'b0, 1'b1, 2'b01, 64'h2203);
        checks++; if (alu_degraded !== 3'b001 || mon_state !== 2'b01 || err_cnt1 !== 16'd7) begin
            $display("FAIL persist_4 got deg=%b st=%b c1=%0d exp 001/01/7", alu_degraded, mon_state, err_cnt1); failures++; end
        log_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            checks++; if (log_valid !== 1'b1 || log_id !== 2'd1) begin
                $display("FAIL persist_drain%0d got lv=%b id=%0d exp 1/1", i, log_valid, log_id); failures++; end
            @(negedge clk);
        end
        log_ready = 1'b0;
        checks++; if (log_valid !== 1'b0 || fault_irq !== 1'b0) begin
            $display("FAIL persist_empty got lv=%b irq=%b exp 0/0", log_valid, fault_irq); failures++; end
    endtask

    task automatic test_uncorr_clear();
        do_op(1'b0, 1'b0, 1'b0, 2'b10, 64'h2040);
        checks++; if (mon_state !== 2'b10 || log_valid !== 1'b1 || log_id !== 2'd0 || fault_irq !== 1'b1) begin
            $display("FAIL uncorr got st=%b lv=%b id=%0d irq=%b exp 10/1/0/1", mon_state, log_valid, log_id, fault_irq); failures++; end
        checks++; if (log_pc !== exp_pc(64'h2040) || err_cnt1 !== 16'd7) begin
            $display("FAIL uncorr_pc got pc=%h c1=%0d exp %h/7", log_pc, err_cnt1, exp_pc(64'h2040)); failures++; end
        do_op(1'b0, 1'b0, 1'b1, 2'b01, 64'h2050);
        checks++; if (mon_state !== 2'b10) begin
            $display("FAIL failed_absorb got st=%b exp 10", mon_state); failures++; end
        pulse_clear();
        checks++; if (mon_state !== 2'b00 || alu_degraded !== 3'b000 || err_cnt1 !== 16'd0 || log_valid !== 1'b0 || fault_irq !== 1'b0) begin
            $display("FAIL clear got st=%b deg=%b c1=%0d lv=%b irq=%b exp all 0", mon_state, alu_degraded, err_cnt1, log_valid, fault_irq); failures++; end
        clear = 1'b1;
        do_op(1'b1, 1'b0, 1'b0, 2'b01, 64'h2060);
        clear = 1'b0;
        checks++; if (err_cnt3 !== 16'd0 || log_valid !== 1'b0) begin
            $display("FAIL clear_prio got c3=%0d lv=%b exp 0/0", err_cnt3, log_valid); failures++; end
    endtask

    task automatic test_overflow();
        log_ready = 1'b0;
        for (int i = 1; i <= 8; i++) do_op(1'b0, 1'b1, 1'b0, 2'b01, 64'h100 * 64'(i));
        checks++; if (log_valid !== 1'b1 || log_overflow !== 1'b0) begin
            $display("FAIL ovf_8 got lv=%b ovf=%b exp 1/0", log_valid, log_overflow); failures++; end
        do_op(1'b0, 1'b1, 1'b0, 2'b01, 64'h900);
        checks++; if (log_overflow !== 1'b1 || err_cnt2 !== 16'd9 || alu_degraded !== 3'b010 || mon_state !== 2'b01) begin
            $display("FAIL ovf_9 got ovf=%b c2=%0d deg=%b st=%b exp 1/9/010/01", log_overflow, err_cnt2, alu_degraded, mon_state); failures++; end
        checks++; if (log_pc !== exp_pc(64'h100) || log_id !== 2'd2) begin
            $display("FAIL ovf_head got pc=%h id=%0d exp %h/2", log_pc, log_id, exp_pc(64'h100)); failures++; end
        log_ready = 1'b1;
        do_op(1'b1, 1'b0, 1'b0, 2'b01, 64'hABC);
        for (int i = 2; i <= 8; i++) begin
            checks++; if (log_valid !== 1'b1 || log_id !== 2'd2 || log_pc !== exp_pc(64'h100 * 64'(i))) begin
                $display("FAIL ovf_drain%0d got lv=%b id=%0d pc=%h exp 1/2/%h", i, log_valid, log_id, log_pc, exp_pc(64'h100 * 64'(i))); failures++; end
            @(negedge clk);
        end
        checks++; if (log_valid !== 1'b1 || log_id !== 2'd3 || log_pc !== exp_pc(64'hABC)) begin
            $display("FAIL ovf_pushpop got lv=%b id=%0d pc=%h exp 1/3/%h", log_valid, log_id, log_pc, exp_pc(64'hABC)); failures++; end
        @(negedge clk);
        log_ready = 1'b0;
        checks++; if (log_valid !== 1'b0 || log_overflow !== 1'b1 || fault_irq !== 1'b1) begin
            $display("FAIL ovf_end got lv=%b ovf=%b irq=%b exp 0/1/1", log_valid, log_overflow, fault_irq); failures++; end
    endtask

    task automatic test_inconsistent();
        pulse_clear();
        do_op(1'b1, 1'b0, 1'b0, 2'b00, 64'h3000);
        checks++; if (mon_state !== 2'b10 || log_id !== 2'd0 || log_valid !== 1'b1 || err_cnt3 !== 16'd0) begin
            $display("FAIL incons_single got st=%b id=%0d lv=%b c3=%0d exp 10/0/1/0", mon_state, log_id, log_valid, err_cnt3); failures++; end
        pulse_clear();
        do_op(1'b1, 1'b1, 1'b1, 2'b01, 64'h3010);
        checks++; if (mon_state !== 2'b10 || log_id !== 2'd0 || log_valid !== 1'b1) begin
            $display("FAIL incons_all got st=%b id=%0d lv=%b exp 10/0/1", mon_state, log_id, log_valid); failures++; end
    endtask

    task automatic test_saturation();
        pulse_clear();
        log_ready = 1'b1;
        for (int i = 0; i < 65535; i++) do_op(1'b0, 1'b0, 1'b1, 2'b01, 64'h4000);
        checks++; if (err_cnt1 !== 16'hFFFF || alu_degraded !== 3'b001) begin
            $display("FAIL sat_reach got c1=%h deg=%b exp ffff/001", err_cnt1, alu_degraded); failures++; end
        do_op(1'b0, 1'b0, 1'b1, 2'b01, 64'h4004);
        checks++; if (err_cnt1 !== 16'hFFFF || log_overflow !== 1'b0) begin
            $display("FAIL sat_hold got c1=%h ovf=%b exp ffff/0", err_cnt1, log_overflow); failures++; end
        log_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_no_event();
        test_single_alu3();
        test_persist();
        test_uncorr_clear();
        test_overflow();
        test_inconsistent();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
